// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - XGA 1024x768@60 raster timing constants shared by the video pipeline.
package vga_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = 2 ** CNT_W;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle passed from the generator to the draw stages.
interface vga_timing_gen_if;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;
  logic frame_start;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start);

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with blank and sync flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160
) (
  input  logic pclk,
  input  logic rst,
  input  logic inc_i,
  output cnt_t count_o,
  output logic blnk_o,
  output logic sync_o,
  output logic wrap_o
);

  localparam int   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
  localparam cnt_t BLNK_START = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FP);
  localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FP + SYNC - 1);

  generate
    if (TOTAL > CNT_MAX) begin : g_total_chk
      $error("vga_axis_counter: axis total exceeds counter range");
    end
  endgenerate

  cnt_t count_q, count_d;
  logic blnk_q, blnk_d;
  logic sync_q, sync_d;

  assign wrap_o = inc_i && (count_q == LAST);

  // Flags decode the next count so they land in the same flop stage as it.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + cnt_t'(1);
    end
    blnk_d = (count_d >= BLNK_START);
    sync_d = (count_d >= SYNC_START) && (count_d <= SYNC_END);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign blnk_o  = blnk_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: two axis counters plus the frame_start strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic pclk,
  input  logic rst,
  input  logic en,
  vga_timing_gen_if.master vga
);

  logic h_wrap, v_wrap;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .pclk   (pclk),
    .rst    (rst),
    .inc_i  (en),
    .count_o(vga.hcount),
    .blnk_o (vga.hblnk),
    .sync_o (vga.hsync),
    .wrap_o (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .pclk   (pclk),
    .rst    (rst),
    .inc_i  (en & h_wrap),
    .count_o(vga.vcount),
    .blnk_o (vga.vblnk),
    .sync_o (vga.vsync),
    .wrap_o (v_wrap)
  );

  // Held while stalled so a strobe already showing stays visible until the next enabled edge.
  assign frame_start_d = en ? v_wrap : frame_start_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen at XGA and at a reduced raster.
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst_x, en_x, rst_s, en_s;
  int   total = 0;
  int   bad   = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen_if vif_x ();
  vga_timing_gen_if vif_s ();

  vga_timing_gen u_dut_x (
    .pclk(pclk), .rst(rst_x), .en(en_x), .vga(vif_x.master)
  );

  // Small raster: H 16/2/3/4 (total 25), V 8/1/2/3 (total 14), frame 350 cycles.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_dut_s (
    .pclk(pclk), .rst(rst_s), .en(en_s), .vga(vif_s.master)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // flags are {hsync, vsync, hblnk, vblnk, frame_start}
  task automatic chk_x(input string tag, input int h, input int v, input logic [4:0] flags);
    check({tag, ".hcount"}, 32'(vif_x.hcount), h);
    check({tag, ".vcount"}, 32'(vif_x.vcount), v);
    check({tag, ".flags"},  32'({vif_x.hsync, vif_x.vsync, vif_x.hblnk, vif_x.vblnk, vif_x.frame_start}), 32'(flags));
  endtask

  task automatic chk_s(input string tag, input int h, input int v, input logic [4:0] flags);
    check({tag, ".hcount"}, 32'(vif_s.hcount), h);
    check({tag, ".vcount"}, 32'(vif_s.vcount), v);
    check({tag, ".flags"},  32'({vif_s.hsync, vif_s.vsync, vif_s.hblnk, vif_s.vblnk, vif_s.frame_start}), 32'(flags));
  endtask

  initial begin
    int n_hs, last_hs;
    int nfs, nvs, nvb, nhs, nhb, vmin, vmax;
    int npulse;
    int p [4];

    rst_x = 1'b1; en_x = 1'b1;
    rst_s = 1'b1; en_s = 1'b1;
    repeat (10) tick();
    chk_x("x_reset", 0, 0, 5'b00000);
    chk_s("s_reset", 0, 0, 5'b00000);

    // XGA line: blanking edge, stall before hsync, hsync width, line wrap
    rst_x = 1'b0;
    tick();
    chk_x("x_first", 1, 0, 5'b00000);
    repeat (1022) tick();
    chk_x("x_h1023", 1023, 0, 5'b00000);
    tick();
    chk_x("x_h1024", 1024, 0, 5'b00100);
    repeat (23) tick();
    chk_x("x_h1047", 1047, 0, 5'b00100);
    en_x = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_x("x_stall", 1047, 0, 5'b00100);
    end
    en_x = 1'b1;
    tick();
    chk_x("x_h1048", 1048, 0, 5'b10100);
    n_hs = 1;
    last_hs = 1048;
    repeat (295) begin
      tick();
      if (vif_x.hsync) begin
        n_hs++;
        last_hs = int'(vif_x.hcount);
      end
    end
    check("x_hsync_len", n_hs, 136);
    check("x_hsync_last", last_hs, 1183);
    chk_x("x_h1343", 1343, 0, 5'b00100);
    tick();
    chk_x("x_line_wrap", 0, 1, 5'b00000);

    // Reduced raster: first full frame, no strobe out of reset
    rst_s = 1'b0;
    tick();
    chk_s("s_first", 1, 0, 5'b00000);
    nfs = 0; nvs = 0; nvb = 0; nhs = 0; nhb = 0; vmin = 99; vmax = -1;
    repeat (348) begin
      tick();
      if (vif_s.frame_start) nfs++;
      if (vif_s.hsync) nhs++;
      if (vif_s.hblnk) nhb++;
      if (vif_s.vblnk) nvb++;
      if (vif_s.vsync) begin
        nvs++;
        if (int'(vif_s.vcount) < vmin) vmin = int'(vif_s.vcount);
        if (int'(vif_s.vcount) > vmax) vmax = int'(vif_s.vcount);
      end
    end
    check("s_no_reset_strobe", nfs, 0);
    check("s_hsync_cycles", nhs, 42);
    check("s_hblnk_cycles", nhb, 126);
    check("s_vblnk_cycles", nvb, 150);
    check("s_vsync_cycles", nvs, 50);
    check("s_vsync_first_line", vmin, 9);
    check("s_vsync_last_line", vmax, 10);
    chk_s("s_frame_end", 24, 13, 5'b00110);
    tick();
    chk_s("s_frame_wrap", 0, 0, 5'b00001);
    en_s = 1'b0;
    repeat (3) begin
      tick();
      chk_s("s_strobe_hold", 0, 0, 5'b00001);
    end
    en_s = 1'b1;
    tick();
    chk_s("s_after_strobe", 1, 0, 5'b00000);

    // Periodicity across three frames
    npulse = 0;
    for (int i = 1; i <= 1060; i++) begin
      tick();
      if (vif_s.frame_start) begin
        if (npulse < 4) p[npulse] = i;
        npulse++;
      end
    end
    check("s_pulse_count", npulse, 3);
    check("s_pulse0_at", p[0], 349);
    check("s_pulse_gap01", p[1] - p[0], 350);
    check("s_pulse_gap12", p[2] - p[1], 350);

    // Mid-frame reset, asserted with en low to show reset wins
    repeat (124) tick();
    chk_s("s_pre_reset", 10, 5, 5'b00000);
    rst_s = 1'b1;
    en_s  = 1'b0;
    tick();
    chk_s("s_mid_reset", 0, 0, 5'b00000);
    rst_s = 1'b0;
    en_s  = 1'b1;
    tick();
    chk_s("s_resume", 1, 0, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 1024x768 @ 60 Hz (XGA, 65 MHz pixel clock) raster timing that feeds the head of the video pipeline. It produces the hcount/vcount/hsync/vsync/hblnk/vblnk bundle consumed by draw_background and every later draw stage. Output flags are registered and cycle-aligned with the counts. It also issues a one-cycle frame_start strobe for game-logic updates.

## Interface

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch

Ports:
- pclk  in  1  pixel clock, 65 MHz
- rst  in  1  reset, synchronous, active-high
- en  in  1  pixel advance enable; tied 1 in the XGA build
- hcount  out  11  horizontal position, 0..H_TOTAL-1
- vcount  out  11  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- hblnk  out  1  horizontal blanking
- vblnk  out  1  vertical blanking
- frame_start  out  1  one-cycle strobe when (hcount,vcount) becomes (0,0)

## Operation

- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1344; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 806. Both must be ≤ 2048. This is an elaboration-time check.
- Horizontal counter: increments on each pclk edge with en=1. H_TOTAL-1 wraps to 0.
- Vertical counter: increments only when hcount wraps. (H_TOTAL-1, V_TOTAL-1) wraps to (0,0).
- hblnk = 1 for hcount in [H_ACTIVE, H_TOTAL-1], i.e. 1024..1343.
- hsync = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1048..1183.
- vblnk = 1 for vcount in [V_ACTIVE, V_TOTAL-1], i.e. 768..805, over whole lines.
- vsync = 1 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 771..776, over whole lines.
- frame_start = 1 for exactly one enabled cycle, the cycle in which the outputs first show (0,0) after a wrap.
- en=0: every output, including frame_start, holds its previous value. A frame_start already high stays high while stalled.
- Sync polarity is active-high on this interface. The top level inverts for the XGA negative-polarity pads.

## Timing

- Reset values: hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0.
- Reset has priority over en. Reset mid-frame returns to (0,0) on the next edge with all flags low.
- First enabled edge after rst falls: outputs show (1,0).
- No frame_start is issued for the frame that starts out of reset. The first strobe comes after the first full frame, at output cycle H_TOTAL*V_TOTAL = 1083264 cycles after reset release.
- All flags are computed from the next-count values and registered in the same flop stage as the counts. Zero skew between counts and flags; latency from counter state to flag is 0 cycles.
- Line period: 1344 cycles. Frame period: 1083264 cycles, about 16.66 ms at 65 MHz.
- Simultaneous events: at (1343,805) → (0,0), hblnk falls, vblnk falls and frame_start rises, all in the same cycle.

## Structure

- The shared package vga_pkg holds the XGA timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL) and the 11-bit count width. draw_* stages reference the active-area limits from this package.
- One natural sub-module is vga_axis_counter. It is a parameterised counter producing count, blnk and sync from ACTIVE/FP/SYNC/BP, with an inc input and a wrap output.
  - It is instantiated twice. The horizontal instance has inc=en.
  - The vertical instance has inc=en & h_wrap.
- The top holds only the frame_start register and the output wiring.

## Test plan

- Reset, then hold rst=1 for 10 cycles → all outputs 0. First edge after release → hcount=1, vcount=0.
- Run one line → hblnk rises when hcount=1024. hsync is high for hcount 1048..1183 (exactly 136 cycles). hcount goes 1343→0 and vcount goes 0→1 on the same edge.
- Run a full frame → vblnk is high for vcount 768..805. vsync is high for vcount 771..776 (6×1344 = 8064 cycles). At (1343,805)→(0,0), frame_start is high for exactly 1 cycle and no strobe appears at reset release.
- Drive en=0 for 5 cycles at hcount=1047 → all outputs frozen for 5 cycles. hsync rises only on the first enabled edge, showing hcount=1048.
- Assert rst for 1 cycle at (600,400) → next cycle shows (0,0) with all flags 0, then counting resumes at (1,0).
- Check periodicity over 3 frames → frame_start pulses are spaced exactly 1083264 enabled cycles apart.
